// File: rtl/vgpr_wr_port_arbiter.sv
// VGPR write-port arbiter: round-robin with an optional high-priority class,
// locked multi-cycle bursts bounded by MAX_LOCK, and a sticky timeout flag.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req[7:0]        write pending per requester
//   req_lock[7:0]   requester wants to keep its grant beyond one cycle
//   hold            no new grant issued this cycle (ignored mid-burst)
//   gnt[7:0]        registered one-hot/zero grant
//   wr_port_select  registered one-hot mux select, [7:0]==gnt, [15:8]==0
//   busy            registered, a grant is active this cycle
//   lock_timeout    sticky, a lock was force-released
//   timeout_clr     clears lock_timeout (a simultaneous new timeout wins)
module vgpr_wr_port_arbiter #(
  parameter logic [7:0]  PRIO_MASK = 8'h00,
  parameter int unsigned MAX_LOCK  = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [7:0]  req_lock,
  input  logic        hold,
  output logic [7:0]  gnt,
  output logic [15:0] wr_port_select,
  output logic        busy,
  output logic        lock_timeout,
  input  logic        timeout_clr
);

  localparam int unsigned N     = 8;
  localparam int unsigned PTR_W = 3;

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   cnt;

  logic               keep_c;
  logic               cont_c;
  logic               forced_c;
  logic [PTR_W-1:0]   base_ptr_c;
  logic [N-1:0]       pool_c;
  logic [N-1:0]       cand_c;
  logic [PTR_W-1:0]   idx_c;
  logic [PTR_W-1:0]   win_idx_c;
  logic               win_vld_c;
  logic [N-1:0]       win_oh_c;

  // Burst continuation, release type and round-robin winner search.
  always_comb begin
    keep_c     = (state != IDLE) && req_lock[owner] && req[owner];
    cont_c     = keep_c && (32'(cnt) < MAX_LOCK);
    forced_c   = keep_c && !cont_c;
    // On release the pointer moves past the owner in the same edge.
    base_ptr_c = (state == IDLE) ? rr_ptr : PTR_W'(owner + PTR_W'(1));
    // A force-released owner must re-request, so it is excluded this edge.
    pool_c     = forced_c ? (req & ~(N'(1) << owner)) : req;
    cand_c     = ((pool_c & PRIO_MASK) != '0) ? (pool_c & PRIO_MASK) : pool_c;
    idx_c      = '0;
    win_idx_c  = '0;
    win_vld_c  = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_c = PTR_W'(base_ptr_c + PTR_W'(i));
      if (!win_vld_c && cand_c[idx_c]) begin
        win_vld_c = 1'b1;
        win_idx_c = idx_c;
      end
    end
    win_oh_c = N'(1) << win_idx_c;
  end

  // State, grant and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      cnt            <= '0;
      gnt            <= '0;
      wr_port_select <= '0;
      busy           <= 1'b0;
      lock_timeout   <= 1'b0;
    end else begin
      if (forced_c) begin
        lock_timeout <= 1'b1;
      end else if (timeout_clr) begin
        lock_timeout <= 1'b0;
      end

      if (cont_c) begin
        state <= LOCKED;
        cnt   <= CNT_W'(cnt + CNT_W'(1));
      end else begin
        if (state != IDLE) begin
          rr_ptr <= base_ptr_c;
        end
        if (!hold && win_vld_c) begin
          state          <= GRANT;
          owner          <= win_idx_c;
          cnt            <= CNT_W'(1);
          gnt            <= win_oh_c;
          wr_port_select <= {8'h00, win_oh_c};
          busy           <= 1'b1;
        end else begin
          state          <= IDLE;
          cnt            <= '0;
          gnt            <= '0;
          wr_port_select <= '0;
          busy           <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vgpr_wr_port_arbiter.sv
// Bench for vgpr_wr_port_arbiter: two instances (no priority class, and
// PRIO_MASK=8'h10) share stimulus; an integer-level reference model tracks
// owner, burst length, round-robin pointer and the timeout flag per instance.
module tb_vgpr_wr_port_arbiter;

  localparam int ML = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [7:0]  req_lock;
  logic        hold;
  logic        timeout_clr;

  logic [7:0]  gnt0, gnt1;
  logic [15:0] sel0, sel1;
  logic        busy0, busy1;
  logic        tmo0, tmo1;

  int checks;
  int errors;

  int         m_owner [2];
  int         m_burst [2];
  int         m_rr    [2];
  logic       m_tmo   [2];
  logic [7:0] m_pm    [2];

  vgpr_wr_port_arbiter #(.PRIO_MASK(8'h00), .MAX_LOCK(ML), .CNT_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .hold(hold),
    .gnt(gnt0), .wr_port_select(sel0), .busy(busy0),
    .lock_timeout(tmo0), .timeout_clr(timeout_clr));

  vgpr_wr_port_arbiter #(.PRIO_MASK(8'h10), .MAX_LOCK(ML), .CNT_W(5)) u_pri (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .hold(hold),
    .gnt(gnt1), .wr_port_select(sel1), .busy(busy1),
    .lock_timeout(tmo1), .timeout_clr(timeout_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // First requester at or after start (wrapping) in the priority pool if any
  // priority requester is present, otherwise among all requesters.
  function automatic int pick(input logic [7:0] r, input logic [7:0] pm, input int start);
    logic [7:0] c;
    c = ((r & pm) != 8'h00) ? (r & pm) : r;
    for (int k = 0; k < 8; k++) begin
      if (c[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_gnt(input int d);
    logic [7:0] g;
    g = 8'h00;
    if (m_owner[d] >= 0) g[m_owner[d]] = 1'b1;
    return g;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_burst[d] = 0;
      m_rr[d]    = 0;
      m_tmo[d]   = 1'b0;
    end
  endtask

  // Reference behaviour of one instance across one rising edge.
  task automatic model_step(input int d);
    logic [7:0] r;
    int excl;
    bit locked;
    excl   = -1;
    locked = (m_owner[d] >= 0) && req_lock[m_owner[d]] && req[m_owner[d]];
    if (locked && m_burst[d] >= ML) begin
      m_tmo[d] = 1'b1;
      excl     = m_owner[d];
    end else if (timeout_clr) begin
      m_tmo[d] = 1'b0;
    end
    if (locked && m_burst[d] < ML) begin
      m_burst[d]++;
      return;
    end
    if (m_owner[d] >= 0) m_rr[d] = (m_owner[d] + 1) % 8;
    r = req;
    if (excl >= 0) r[excl] = 1'b0;
    m_owner[d] = hold ? -1 : pick(r, m_pm[d], m_rr[d]);
    m_burst[d] = (m_owner[d] >= 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("dut0_gnt",  {8'h00, gnt0}, {8'h00, exp_gnt(0)});
    check("dut0_sel",  sel0,          {8'h00, exp_gnt(0)});
    check("dut0_busy", {15'h0, busy0}, {15'h0, (m_owner[0] >= 0)});
    check("dut0_tmo",  {15'h0, tmo0},  {15'h0, m_tmo[0]});
    check("dut1_gnt",  {8'h00, gnt1}, {8'h00, exp_gnt(1)});
    check("dut1_sel",  sel1,          {8'h00, exp_gnt(1)});
    check("dut1_busy", {15'h0, busy1}, {15'h0, (m_owner[1] >= 0)});
    check("dut1_tmo",  {15'h0, tmo1},  {15'h0, m_tmo[1]});
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    req = 8'h00; req_lock = 8'h00; hold = 1'b0; timeout_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_pm[0] = 8'h00;
    m_pm[1] = 8'h10;
    model_reset();
    rst_n = 1'b0; req = 8'h00; req_lock = 8'h00; hold = 1'b0; timeout_clr = 1'b0;
    @(posedge clk);
    #1;
    compare_all();
    #2;
    rst_n = 1'b1;

    // Async reset mid-activity with all requesters pending.
    req = 8'hFF;
    cycle();
    cycle();
    check("pre_reset_busy", {15'h0, busy0}, 16'h0001);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_gnt",  {8'h00, gnt0}, 16'h0000);
    check("rst_sel",  sel0, 16'h0000);
    check("rst_busy", {15'h0, busy0}, 16'h0000);
    check("rst_tmo",  {15'h0, tmo0}, 16'h0000);
    do_reset();

    // Round-robin over 0,2,7 back-to-back.
    req = 8'h85;
    cycle(); check("rr_1", {8'h00, gnt0}, 16'h0001);
    cycle(); check("rr_2", {8'h00, gnt0}, 16'h0004);
    cycle(); check("rr_3", {8'h00, gnt0}, 16'h0080);
    cycle(); check("rr_4", {8'h00, gnt0}, 16'h0001);
    check("rr_sel", sel0, 16'h0001);
    req = 8'h00;
    cycle(); check("rr_idle", {8'h00, gnt0}, 16'h0000);

    // Priority class on the second instance.
    do_reset();
    req = 8'h13;
    for (int k = 0; k < 3; k++) begin
      cycle(); check("prio_hi", {8'h00, gnt1}, 16'h0010);
    end
    req = 8'h03;
    cycle(); check("prio_after_1", {8'h00, gnt1}, 16'h0001);
    cycle(); check("prio_after_2", {8'h00, gnt1}, 16'h0002);
    req = 8'h00;
    cycle();

    // Four-cycle lock, then next requester with no bubble.
    do_reset();
    req = 8'h06; req_lock = 8'h02;
    for (int k = 0; k < 4; k++) begin
      cycle(); check("lock_hold", {8'h00, gnt0}, 16'h0002);
    end
    req_lock = 8'h00; req = 8'h04;
    cycle(); check("lock_next", {8'h00, gnt0}, 16'h0004);
    req = 8'h00;
    cycle(); check("lock_idle", {8'h00, gnt0}, 16'h0000);

    // Stuck lock forced out after MAX_LOCK cycles.
    do_reset();
    req = 8'h08; req_lock = 8'h08;
    for (int k = 0; k < ML; k++) begin
      cycle(); check("tmo_hold", {8'h00, gnt0}, 16'h0008);
    end
    check("tmo_not_yet", {15'h0, tmo0}, 16'h0000);
    cycle(); check("tmo_release", {8'h00, gnt0}, 16'h0000);
    check("tmo_set", {15'h0, tmo0}, 16'h0001);
    req = 8'h00; req_lock = 8'h00;
    cycle(); check("tmo_sticky", {15'h0, tmo0}, 16'h0001);
    timeout_clr = 1'b1;
    cycle(); check("tmo_clr", {15'h0, tmo0}, 16'h0000);
    timeout_clr = 1'b0;

    // Hold in IDLE blocks the grant; hold mid-burst does not.
    do_reset();
    req = 8'h01; hold = 1'b1;
    cycle(); check("hold_idle_1", {8'h00, gnt0}, 16'h0000);
    cycle(); check("hold_idle_2", {8'h00, gnt0}, 16'h0000);
    hold = 1'b0;
    cycle(); check("hold_release", {8'h00, gnt0}, 16'h0001);
    req_lock = 8'h01; hold = 1'b1;
    cycle(); check("hold_lock_1", {8'h00, gnt0}, 16'h0001);
    cycle(); check("hold_lock_2", {8'h00, gnt0}, 16'h0001);
    req = 8'h00; req_lock = 8'h00; hold = 1'b0;
    cycle(); check("hold_end", {8'h00, gnt0}, 16'h0000);

    // Randomized traffic against the reference model.
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 23) == 0) req_lock = 8'($urandom);
      hold        = ($urandom_range(0, 9) == 0);
      timeout_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
